dpram_port_arbiter: RTL and testbench
=====================================

# dpram_port_arbiter

Round-robin arbiter that shares one port of the team's true dual-port block RAM (1-cycle registered read, read-first on same-address write) between two requesters. Each requester issues single-beat read/write commands over a req/gnt handshake. The arbiter registers the winning command onto the RAM port and returns read data with a per-requester valid strobe. It sits between the RAM and two client engines that otherwise would each need a dedicated port.

## Interface
- DATA_WIDTH, 32, RAM word width
- ADDR_WIDTH, 8, RAM address width
- clk  in  1  single clock, also drives the shared RAM port
- rst  in  1  reset, synchronous, active-high
- m0_req / m1_req  in  1  command request, held until gnt
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  ADDR_WIDTH  command address
- m0_wdata / m1_wdata  in  DATA_WIDTH  write data
- m0_gnt / m1_gnt  out  1  command accepted this cycle (combinational)
- m0_rvalid / m1_rvalid  out  1  read data valid this cycle (registered)
- m0_rdata / m1_rdata  out  DATA_WIDTH  read data, meaningful only with rvalid
- ram_en  out  1  RAM port enable (registered)
- ram_we  out  1  RAM port write enable (registered)
- ram_addr  out  ADDR_WIDTH  RAM port address (registered)
- ram_din  out  DATA_WIDTH  RAM port write data (registered)
- ram_dout  in  DATA_WIDTH  RAM port read data

## Operation
- Handshake: a command transfers in cycle n when mX_req=1 and mX_gnt=1. Requester keeps req/we/addr/wdata stable until gnt. One command per grant; req held high after gnt is a new command.
- Arbitration: at most one gnt per cycle. Only one requester asserting req wins. Both asserting: the requester not served last wins. last_served updates only on a grant.
- Issue: command granted in cycle n appears on ram_en=1, ram_we, ram_addr, ram_din in cycle n+1. With no grant in cycle n, ram_en=0 and ram_we=0 in cycle n+1, and addr/din hold their last values.
- Read return: RAM samples in cycle n+1, ram_dout is valid in cycle n+2, and the owner's mX_rvalid=1 in cycle n+2. mX_rdata = ram_dout, passed through and unregistered. Writes produce no rvalid.
- Tag pipeline: a 2-stage shift of {valid, id, is_read} tracks in-flight commands. Both stages may be occupied. The ID determines which requester gets rvalid. At most one rvalid is asserted per cycle.
- Throughput: 1 command/cycle total. Under continuous contention, the two requesters alternate grants strictly.
- Hazard: a write followed by a read to the same address in the next cycle returns the new data. A read issued in the same RAM cycle as a write from the other port (other RAM port, not arbitrated here) returns old data. The arbiter does no forwarding.

## Timing
- Reset (rst=1 at a clk edge) gives ram_en=0, ram_we=0, ram_addr=0, ram_din=0, m0_rvalid=m1_rvalid=0, pipeline cleared, last_served=m1 (so m0 wins the first tie). gnt is forced 0 while rst=1.
- Reset mid-operation discards in-flight reads. No rvalid is asserted in the cycle after reset deasserts for commands granted before reset.
- Latency: gnt to RAM access is 1 cycle. gnt to rvalid is 2 cycles.
- gnt depends combinationally on req and last_served. There is no path from gnt back to req inside the block.

## Structure
- Package dpram_arb_pkg:
  - requester ID localparams ID_M0=0, ID_M1=1;
  - RD_LAT=1 (RAM read latency);
  - in-flight tag struct/width {valid, id, is_read}.
- Sub-module rr_arb2 contains the 2-way round-robin grant logic and the last_served register. The top level holds the command mux, RAM output registers and tag pipeline.

## Test plan
- m0 writes 0xDEADBEEF to 0x10 (granted cycle n) -> ram_en=ram_we=1, ram_addr=0x10, ram_din=0xDEADBEEF in n+1; no rvalid.
- m0 reads 0x10 after that write -> m0_gnt in cycle n, m0_rvalid=1 with m0_rdata=0xDEADBEEF in n+2, m1_rvalid stays 0.
- Both req read continuously from reset (m0 addr 0x01, m1 addr 0x02; RAM preloaded with 0xA1 and 0xB2) -> grants m0,m1,m0,m1…; rvalid alternates with 0xA1/0xB2, 1 result per cycle.
- Write 0x55 to 0x20 in cycle n, read 0x20 in n+1 by the other requester -> that read returns 0x55 in n+3.
- m1 read granted, rst pulsed in the next cycle -> no m1_rvalid after reset, all outputs zero; the first tie after reset goes to m0.
- Only m1 requests for 4 cycles -> m1_gnt every cycle and ram_en high 4 consecutive cycles; idle cycles give ram_en=0.

Source files
------------

// File: rtl/dpram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dpram_arb_pkg
// Description : Shared types and constants for dpram_port_arbiter.
//               Requester IDs, the RAM read latency and the in-flight tag
//               layout that tracks commands on their way through the RAM.
// Revision    : 1.0 - initial release
// ============================================================================
package dpram_arb_pkg;

    localparam logic ID_M0  = 1'b0;
    localparam logic ID_M1  = 1'b1;

    // Registered-read latency of the shared RAM port
    localparam int   RD_LAT = 1;

    typedef struct packed {
        logic valid;
        logic id;
        logic is_read;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

    // A tag returns data to requester `id` only if it is a live read
    function automatic logic tag_hit(input tag_t t, input logic id);
        return t.valid && t.is_read && (t.id == id);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dpram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dpram_port_arbiter_if
// Description : Bundles both requester handshakes and the shared RAM port.
//   m0_/m1_ req, we, addr, wdata : requester -> arbiter command
//   m0_/m1_ gnt                  : arbiter -> requester, command accepted
//   m0_/m1_ rvalid, rdata        : arbiter -> requester, read return
//   ram_en, ram_we, ram_addr, ram_din : arbiter -> RAM (registered)
//   ram_dout                     : RAM -> arbiter
//   modport slave  : arbiter side
//   modport master : requesters + RAM side
// Revision    : 1.0 - initial release
// ============================================================================
interface dpram_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  m0_req,    m1_req;
    logic                  m0_we,     m1_we;
    logic [ADDR_WIDTH-1:0] m0_addr,   m1_addr;
    logic [DATA_WIDTH-1:0] m0_wdata,  m1_wdata;
    logic                  m0_gnt,    m1_gnt;
    logic                  m0_rvalid, m1_rvalid;
    logic [DATA_WIDTH-1:0] m0_rdata,  m1_rdata;
    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
        output ram_en, ram_we, ram_addr, ram_din,
        input  ram_dout
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
        input  ram_en, ram_we, ram_addr, ram_din,
        output ram_dout
    );

endinterface
`default_nettype wire

// File: rtl/dpram_port_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin grant with last-served memory.
//   clk, rst          : clock, synchronous active-high reset
//   i_req0, i_req1    : requests
//   o_gnt0, o_gnt1    : one-hot (or zero) grant, combinational from
//                       requests and the last-served register
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import dpram_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_gnt0,
    output logic o_gnt1
);

    logic r_last_served;

    // On a tie the requester that was not served last wins
    always_comb begin
        o_gnt0 = 1'b0;
        o_gnt1 = 1'b0;
        if (!rst) begin
            if (i_req0 && (!i_req1 || (r_last_served == ID_M1))) begin
                o_gnt0 = 1'b1;
            end else if (i_req1) begin
                o_gnt1 = 1'b1;
            end
        end
    end

    // Reset to m1 so that m0 takes the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_served <= ID_M1;
        end else if (o_gnt0) begin
            r_last_served <= ID_M0;
        end else if (o_gnt1) begin
            r_last_served <= ID_M1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dpram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dpram_port_arbiter
// Description : Shares one port of a 1-cycle registered-read RAM between two
//               single-beat requesters. The winning command is registered
//               onto the RAM port; a tag pipeline routes the read data back
//               to its owner two cycles after the grant.
//   clk  : single clock, also clocks the RAM port
//   rst  : synchronous active-high reset
//   bus  : dpram_port_arbiter_if.slave (requester handshakes + RAM port)
// Revision    : 1.0 - initial release
// ============================================================================
module dpram_port_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    dpram_port_arbiter_if.slave  bus
);

    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_any_gnt;
    logic                  w_sel_id;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

    logic                  r_ram_en;
    logic                  r_ram_we;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_din;

    // Stage 0 rides alongside the RAM access, stage RD_LAT lines up with
    // ram_dout
    tag_t                  r_tag [RD_LAT+1];

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst    (rst),
        .i_req0 (bus.m0_req),
        .i_req1 (bus.m1_req),
        .o_gnt0 (w_gnt0),
        .o_gnt1 (w_gnt1)
    );

    assign w_any_gnt   = w_gnt0 | w_gnt1;
    assign w_sel_id    = w_gnt1 ? ID_M1 : ID_M0;
    assign w_sel_we    = w_gnt1 ? bus.m1_we    : bus.m0_we;
    assign w_sel_addr  = w_gnt1 ? bus.m1_addr  : bus.m0_addr;
    assign w_sel_wdata = w_gnt1 ? bus.m1_wdata : bus.m0_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ram_en   <= 1'b0;
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_din  <= '0;
            for (int i = 0; i <= RD_LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_ram_en <= w_any_gnt;
            r_ram_we <= w_any_gnt & w_sel_we;
            // Address and data hold their last value on idle cycles
            if (w_any_gnt) begin
                r_ram_addr <= w_sel_addr;
                r_ram_din  <= w_sel_wdata;
            end
            r_tag[0] <= '{valid: w_any_gnt, id: w_sel_id, is_read: ~w_sel_we};
            for (int i = 1; i <= RD_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign bus.m0_gnt    = w_gnt0;
    assign bus.m1_gnt    = w_gnt1;
    assign bus.ram_en    = r_ram_en;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_din   = r_ram_din;

    // Only one tag reaches the last stage per cycle, so at most one rvalid
    assign bus.m0_rvalid = tag_hit(r_tag[RD_LAT], ID_M0);
    assign bus.m1_rvalid = tag_hit(r_tag[RD_LAT], ID_M1);
    assign bus.m0_rdata  = bus.ram_dout;
    assign bus.m1_rdata  = bus.ram_dout;

endmodule
`default_nettype wire

// File: tb/tb_dpram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dpram_port_arbiter
// Description : Self-checking bench for dpram_port_arbiter with a behavioural
//               RAM attached to the shared port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dpram_port_arbiter;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   mon_on   = 0;

    dpram_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

    dpram_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural RAM port: registered read, read-first
    logic [31:0] tb_ram [256];
    logic [31:0] r_dout;
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) tb_ram[bus.ram_addr] <= bus.ram_din;
            r_dout <= tb_ram[bus.ram_addr];
        end
    end
    assign bus.ram_dout = r_dout;

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        bit          id;
        logic [31:0] data;
    } rd_t;

    rd_t         rq[$];
    logic [31:0] mdl_mem [256];
    bit          m_last;        // 1: m1 served last
    logic        exp_en, exp_we;
    logic [7:0]  exp_addr;
    logic [31:0] exp_din;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, expv);
        end
    endtask

    task automatic model_reset();
        m_last   = 1'b1;
        rq.delete();
        exp_en   = 1'b0;
        exp_we   = 1'b0;
        exp_addr = '0;
        exp_din  = '0;
    endtask

    task automatic mon();
        logic eg0, eg1, ev0, ev1;
        logic [31:0] ed;
        rd_t r;
        eg0 = !rst && bus.m0_req && (!bus.m1_req || m_last);
        eg1 = !rst && bus.m1_req && (!bus.m0_req || !m_last);
        chk("mon_gnt0", bus.m0_gnt, eg0);
        chk("mon_gnt1", bus.m1_gnt, eg1);
        chk("mon_ram_en", bus.ram_en, exp_en);
        chk("mon_ram_we", bus.ram_we, exp_we);
        chk("mon_ram_addr", bus.ram_addr, exp_addr);
        chk("mon_ram_din", bus.ram_din, exp_din);
        ev0 = 0; ev1 = 0; ed = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            if (r.id) ev1 = 1; else ev0 = 1;
            ed = r.data;
        end
        chk("mon_rvalid0", bus.m0_rvalid, ev0);
        chk("mon_rvalid1", bus.m1_rvalid, ev1);
        if (ev0) chk("mon_rdata0", bus.m0_rdata, ed);
        if (ev1) chk("mon_rdata1", bus.m1_rdata, ed);
        if (rst) begin
            model_reset();
        end else begin
            exp_en = eg0 | eg1;
            exp_we = 1'b0;
            if (eg0 || eg1) begin
                logic        we;
                logic [7:0]  a;
                logic [31:0] d;
                we = eg1 ? bus.m1_we    : bus.m0_we;
                a  = eg1 ? bus.m1_addr  : bus.m0_addr;
                d  = eg1 ? bus.m1_wdata : bus.m0_wdata;
                exp_we = we; exp_addr = a; exp_din = d;
                if (we) mdl_mem[a] = d;
                else    rq.push_back('{due: cyc + 2, id: eg1, data: mdl_mem[a]});
                m_last = eg1;
            end
        end
    endtask

    task automatic half();
        @(negedge clk);
        if (mon_on) mon();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [7:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [7:0] a1, input logic [31:0] d1);
        bus.m0_req = r0; bus.m0_we = w0; bus.m0_addr = a0; bus.m0_wdata = d0;
        bus.m1_req = r1; bus.m1_we = w1; bus.m1_addr = a1; bus.m1_wdata = d1;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) begin
            half();
            adv();
        end
    endtask

    typedef struct {
        bit r0, r1, g0, g1;
    } vec_t;

    vec_t vecs [10];
    bit   p0, p1;

    initial begin
        // Arbitration sequence from reset; last_served starts at m1
        vecs[0] = '{0, 0, 0, 0};
        vecs[1] = '{1, 1, 1, 0};
        vecs[2] = '{1, 1, 0, 1};
        vecs[3] = '{1, 0, 1, 0};
        vecs[4] = '{1, 0, 1, 0};
        vecs[5] = '{1, 1, 0, 1};
        vecs[6] = '{0, 1, 0, 1};
        vecs[7] = '{1, 1, 1, 0};
        vecs[8] = '{0, 0, 0, 0};
        vecs[9] = '{1, 1, 0, 1};

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 256; i++) begin
            tb_ram[i]  = {i[7:0], i[7:0], i[7:0], i[7:0]} ^ 32'h5A5A_0000;
            mdl_mem[i] = tb_ram[i];
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        model_reset();
        mon_on = 1;
        half();
        chk("reset_ram_en", bus.ram_en, 0);
        chk("reset_ram_addr", bus.ram_addr, 0);
        chk("reset_rvalid0", bus.m0_rvalid, 0);
        adv();
        rst = 1'b0;

        // Table-driven arbitration
        for (int k = 0; k < 10; k++) begin
            drive(vecs[k].r0, 0, 8'(k), 32'(k), vecs[k].r1, 0, 8'(k + 16), 32'(k));
            half();
            chk("tbl_gnt0", bus.m0_gnt, vecs[k].g0);
            chk("tbl_gnt1", bus.m1_gnt, vecs[k].g1);
            adv();
        end
        idle(3);

        // m0 write 0xDEADBEEF to 0x10
        drive(1, 1, 8'h10, 32'hDEADBEEF, 0, 0, 0, 0);
        half(); chk("wr_gnt0", bus.m0_gnt, 1); adv();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        half();
        chk("wr_ram_en", bus.ram_en, 1);
        chk("wr_ram_we", bus.ram_we, 1);
        chk("wr_ram_addr", bus.ram_addr, 8'h10);
        chk("wr_ram_din", bus.ram_din, 32'hDEADBEEF);
        adv();
        half(); chk("wr_no_rvalid", bus.m0_rvalid, 0); adv();

        // m0 read back 0x10
        drive(1, 0, 8'h10, 0, 0, 0, 0, 0);
        half(); chk("rd_gnt0", bus.m0_gnt, 1); adv();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        half(); adv();
        half();
        chk("rd_rvalid0", bus.m0_rvalid, 1);
        chk("rd_rdata0", bus.m0_rdata, 32'hDEADBEEF);
        chk("rd_rvalid1", bus.m1_rvalid, 0);
        adv();
        idle(2);

        // Continuous contention from reset
        rst = 1'b1; idle(1); rst = 1'b0;
        tb_ram[1] = 32'hA1; mdl_mem[1] = 32'hA1;
        tb_ram[2] = 32'hB2; mdl_mem[2] = 32'hB2;
        drive(1, 0, 8'h01, 0, 1, 0, 8'h02, 0);
        for (int k = 0; k < 8; k++) begin
            half();
            chk("alt_gnt0", bus.m0_gnt, (k % 2) == 0);
            chk("alt_gnt1", bus.m1_gnt, (k % 2) == 1);
            if (k >= 2) begin
                chk("alt_rvalid0", bus.m0_rvalid, (k % 2) == 0);
                chk("alt_rvalid1", bus.m1_rvalid, (k % 2) == 1);
                if (k % 2 == 0) chk("alt_rdata0", bus.m0_rdata, 32'hA1);
                else            chk("alt_rdata1", bus.m1_rdata, 32'hB2);
            end
            adv();
        end
        idle(3);

        // Write then read by the other requester next cycle
        drive(1, 1, 8'h20, 32'h55, 0, 0, 0, 0);
        half(); adv();
        drive(0, 0, 0, 0, 1, 0, 8'h20, 0);
        half(); chk("haz_gnt1", bus.m1_gnt, 1); adv();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        half(); adv();
        half();
        chk("haz_rvalid1", bus.m1_rvalid, 1);
        chk("haz_rdata1", bus.m1_rdata, 32'h55);
        adv();
        idle(2);

        // m1 read in flight, then reset
        drive(0, 0, 0, 0, 1, 0, 8'h03, 0);
        half(); chk("rst_gnt1", bus.m1_gnt, 1); adv();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        half(); adv();
        rst = 1'b0;
        half();
        chk("rst_rvalid1", bus.m1_rvalid, 0);
        chk("rst_rvalid0", bus.m0_rvalid, 0);
        chk("rst_ram_en", bus.ram_en, 0);
        chk("rst_ram_we", bus.ram_we, 0);
        chk("rst_ram_addr", bus.ram_addr, 0);
        chk("rst_ram_din", bus.ram_din, 0);
        adv();
        drive(1, 0, 8'h04, 0, 1, 0, 8'h05, 0);
        half();
        chk("rst_tie_gnt0", bus.m0_gnt, 1);
        chk("rst_tie_gnt1", bus.m1_gnt, 0);
        adv();
        idle(3);

        // Only m1 for 4 cycles
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 0, 0, k < 4, 0, 8'(k), 0);
            half();
            if (k < 4) chk("solo_gnt1", bus.m1_gnt, 1);
            if (k >= 1 && k <= 4) chk("solo_ram_en", bus.ram_en, 1);
            if (k == 5) chk("solo_ram_en_idle", bus.ram_en, 0);
            adv();
        end
        idle(2);

        // Randomized traffic against the model
        p0 = 0; p1 = 0;
        for (int k = 0; k < 400; k++) begin
            if (!p0 && $urandom_range(0, 9) < 6) begin
                p0 = 1;
                bus.m0_we    = 1'($urandom_range(0, 1));
                bus.m0_addr  = 8'($urandom_range(0, 7));
                bus.m0_wdata = $urandom;
            end
            if (!p1 && $urandom_range(0, 9) < 6) begin
                p1 = 1;
                bus.m1_we    = 1'($urandom_range(0, 1));
                bus.m1_addr  = 8'($urandom_range(0, 7));
                bus.m1_wdata = $urandom;
            end
            bus.m0_req = p0;
            bus.m1_req = p1;
            rst = ($urandom_range(0, 63) == 0);
            half();
            if (bus.m0_gnt) p0 = 0;
            if (bus.m1_gnt) p1 = 0;
            adv();
        end
        rst = 1'b0;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
